// File: rtl/digit_pattern_gen.sv
// Seven-segment digit test-pattern generator.
// Streams an H_ACT x V_ACT raster over a valid/ready handshake and draws
// NUM_DIGITS BCD digits as seven-segment glyphs (ink = 0/black, bg = 1/white).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   run request (dropping it mid-frame drains the frame)
//   digit_in/digit_load  BCD digits (cell 0 in MSBs) captured into a shadow
//   out_valid/out_ready  pixel handshake
//   xpos, ypos           pixel coordinates
//   monoc, monoc_fall    pixel colour bit and bg->ink transition within row
//   color_rgb            RGB565 colour following monoc
//   sof, eol, eof        first pixel of frame, last of row, last of frame
//   frame_cnt            completed-frame counter (mod 4)
module digit_pattern_gen #(
    parameter int unsigned H_ACT      = 640,
    parameter int unsigned V_ACT      = 480,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CELL_W     = 64,
    parameter int unsigned CELL_H     = 128,
    parameter int unsigned SEG_T      = 8,
    parameter int unsigned GAP        = 32,
    parameter int unsigned X0         = 64,
    parameter int unsigned Y0         = 176
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digit_in,
    input  logic                    digit_load,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [10:0]             xpos,
    output logic [10:0]             ypos,
    output logic                    monoc,
    output logic                    monoc_fall,
    output logic [15:0]             color_rgb,
    output logic                    sof,
    output logic                    eol,
    output logic                    eof,
    output logic [1:0]              frame_cnt
);

    localparam int unsigned CW    = 11;
    localparam int unsigned BW    = 16;
    localparam int unsigned DW    = 4 * NUM_DIGITS;
    localparam int unsigned KW    = $clog2(NUM_DIGITS + 1);
    localparam int unsigned PITCH = CELL_W + GAP;
    localparam int unsigned HALF  = CELL_H / 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          state_q, state_d;
    // Generator position: the next pixel to be issued.
    logic [CW-1:0]   gx_q, gx_d, gy_q, gy_d;
    logic [KW-1:0]   gk_q, gk_d;
    logic [BW-1:0]   gbase_q, gbase_d;
    logic [DW-1:0]   shadow_q, shadow_d, active_q, active_d;
    // Presented pixel.
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   xpos_q, xpos_d, ypos_q, ypos_d;
    logic            monoc_q, monoc_d, monoc_fall_q, monoc_fall_d;
    logic [15:0]     color_q, color_d;
    logic            sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic [1:0]      frame_cnt_q, frame_cnt_d;

    logic [BW-1:0]   cx, cy;
    logic            in_x, in_y, origin, top, left, right, ink;
    logic [DW-1:0]   frame_digits;
    logic [3:0]      cur_digit;
    logic [6:0]      segs, regions;
    logic            xfer, can_issue, last_xfer, issue;

    // Ink evaluation for the generator position (cx tracked via running cell base).
    always_comb begin
        cx        = BW'(gx_q) - gbase_q;
        cy        = BW'(gy_q) - BW'(Y0);
        in_x      = (gk_q < KW'(NUM_DIGITS)) && (BW'(gx_q) >= gbase_q) && (cx < BW'(CELL_W));
        in_y      = (BW'(gy_q) >= BW'(Y0)) && (BW'(gy_q) < BW'(Y0 + CELL_H));
        origin    = (gx_q == '0) && (gy_q == '0);
        // A load landing on the (0,0) issue takes effect for that frame.
        frame_digits = origin ? shadow_d : active_q;
        cur_digit = 4'hF;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (gk_q == KW'(i)) cur_digit = frame_digits[4*(NUM_DIGITS-1-i) +: 4];
        end
        case (cur_digit)            // {a,b,c,d,e,f,g}
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = 7'b0000000;
        endcase
        top     = cy < BW'(HALF);
        left    = cx < BW'(SEG_T);
        right   = cx >= BW'(CELL_W - SEG_T);
        regions = {cy < BW'(SEG_T),
                   right & top,
                   right & ~top,
                   cy >= BW'(CELL_H - SEG_T),
                   left & ~top,
                   left & top,
                   (cy >= BW'(HALF - SEG_T/2)) && (cy < BW'(HALF + SEG_T/2))};
        ink     = in_x && in_y && (|(segs & regions));
    end

    // Next-state, issue and datapath update.
    always_comb begin
        state_d      = state_q;
        gx_d         = gx_q;
        gy_d         = gy_q;
        gk_d         = gk_q;
        gbase_d      = gbase_q;
        shadow_d     = digit_load ? digit_in : shadow_q;
        active_d     = active_q;
        out_valid_d  = out_valid_q;
        xpos_d       = xpos_q;
        ypos_d       = ypos_q;
        monoc_d      = monoc_q;
        monoc_fall_d = monoc_fall_q;
        color_d      = color_q;
        sof_d        = sof_q;
        eol_d        = eol_q;
        eof_d        = eof_q;
        frame_cnt_d  = frame_cnt_q;
        issue        = 1'b0;

        xfer      = out_valid_q && out_ready;
        can_issue = !out_valid_q || out_ready;
        last_xfer = xfer && eof_q;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_RUN;
                    issue   = can_issue;
                end
            end
            S_RUN: begin
                issue = can_issue && !(last_xfer && !en);
                if (!en) state_d = last_xfer ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                issue = can_issue && !last_xfer;
                if (last_xfer) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (last_xfer) frame_cnt_d = frame_cnt_q + 2'd1;
        if (xfer)      out_valid_d = 1'b0;

        if (issue) begin
            out_valid_d  = 1'b1;
            xpos_d       = gx_q;
            ypos_d       = gy_q;
            monoc_d      = !ink;
            // monoc_q still holds the previous pixel of this row when gx != 0.
            monoc_fall_d = ink && (gx_q != '0) && monoc_q;
            color_d      = ink ? 16'h0000 : 16'hffff;
            sof_d        = origin;
            eol_d        = gx_q == CW'(H_ACT - 1);
            eof_d        = (gx_q == CW'(H_ACT - 1)) && (gy_q == CW'(V_ACT - 1));
            if (origin) active_d = shadow_d;
            if (gx_q == CW'(H_ACT - 1)) begin
                gx_d    = '0;
                gk_d    = '0;
                gbase_d = BW'(X0);
                gy_d    = (gy_q == CW'(V_ACT - 1)) ? '0 : gy_q + CW'(1);
            end else begin
                gx_d = gx_q + CW'(1);
                if (in_x && (cx == BW'(CELL_W - 1))) begin
                    gk_d    = gk_q + KW'(1);
                    gbase_d = gbase_q + BW'(PITCH);
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gx_q         <= '0;
            gy_q         <= '0;
            gk_q         <= '0;
            gbase_q      <= BW'(X0);
            shadow_q     <= '1;
            active_q     <= '1;
            out_valid_q  <= 1'b0;
            xpos_q       <= '0;
            ypos_q       <= '0;
            monoc_q      <= 1'b1;
            monoc_fall_q <= 1'b0;
            color_q      <= 16'hffff;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            eof_q        <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            gk_q         <= gk_d;
            gbase_q      <= gbase_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            out_valid_q  <= out_valid_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            monoc_q      <= monoc_d;
            monoc_fall_q <= monoc_fall_d;
            color_q      <= color_d;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
            eof_q        <= eof_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign xpos       = xpos_q;
    assign ypos       = ypos_q;
    assign monoc      = monoc_q;
    assign monoc_fall = monoc_fall_q;
    assign color_rgb  = color_q;
    assign sof        = sof_q;
    assign eol        = eol_q;
    assign eof        = eof_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_digit_pattern_gen.sv
// Testbench for digit_pattern_gen on a reduced raster (44x24, 8x12 cells, the
// last cell clipped by the right edge). Expected pixels are queued per frame
// from a geometric reference model; a negedge monitor pops and compares them.
module tb_digit_pattern_gen;

    localparam int H  = 44;
    localparam int V  = 24;
    localparam int N  = 4;
    localparam int CWD = 8;
    localparam int CHT = 12;
    localparam int ST = 2;
    localparam int GP = 4;
    localparam int XO = 2;
    localparam int YO = 3;
    localparam int FP = H * V;
    localparam int PITCH = CWD + GP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [15:0] digit_in = 16'h0;
    logic        digit_load = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [10:0] xpos, ypos;
    logic        monoc, monoc_fall, sof, eol, eof;
    logic [15:0] color_rgb;
    logic [1:0]  frame_cnt;

    digit_pattern_gen #(
        .H_ACT(H), .V_ACT(V), .NUM_DIGITS(N), .CELL_W(CWD), .CELL_H(CHT),
        .SEG_T(ST), .GAP(GP), .X0(XO), .Y0(YO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digit_in(digit_in),
        .digit_load(digit_load), .out_valid(out_valid), .out_ready(out_ready),
        .xpos(xpos), .ypos(ypos), .monoc(monoc), .monoc_fall(monoc_fall),
        .color_rgb(color_rgb), .sof(sof), .eol(eol), .eof(eof),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x; int y; bit ink; bit fall; bit sof; bit eol; bit eof; int fc;
    } pix_t;

    pix_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    xfer_cnt = 0;
    bit    rand_ready = 0;
    string seg_tbl[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                           "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic bit lit(int d, byte s);
        string t;
        if (d > 9) return 1'b0;
        t = seg_tbl[d];
        for (int i = 0; i < t.len(); i++) if (t[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    // Ink at (x,y) from cell geometry and the segment letter table.
    function automatic bit model_ink(int x, int y, logic [15:0] dig);
        int cx, cy, d, x0;
        bit top;
        if (y < YO || y >= YO + CHT) return 1'b0;
        cy  = y - YO;
        top = cy < CHT / 2;
        for (int k = 0; k < N; k++) begin
            x0 = XO + k * PITCH;
            if (x >= x0 && x < x0 + CWD) begin
                cx = x - x0;
                d  = int'(dig[4*(N-1-k) +: 4]);
                if (lit(d, "a") && cy < ST) return 1'b1;
                if (lit(d, "d") && cy >= CHT - ST) return 1'b1;
                if (lit(d, "g") && cy >= CHT/2 - ST/2 && cy < CHT/2 + ST/2) return 1'b1;
                if (lit(d, "f") && cx < ST && top) return 1'b1;
                if (lit(d, "e") && cx < ST && !top) return 1'b1;
                if (lit(d, "b") && cx >= CWD - ST && top) return 1'b1;
                if (lit(d, "c") && cx >= CWD - ST && !top) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic push_frame(input logic [15:0] dig, input int fc, input int npix);
        pix_t p;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (y * H + x < npix) begin
                    p.x    = x;
                    p.y    = y;
                    p.ink  = model_ink(x, y, dig);
                    p.fall = (x > 0) && p.ink && !model_ink(x - 1, y, dig);
                    p.sof  = (x == 0) && (y == 0);
                    p.eol  = (x == H - 1);
                    p.eof  = (x == H - 1) && (y == V - 1);
                    p.fc   = fc % 4;
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    task automatic wait_xfer(input int target);
        int budget = 0;
        while (xfer_cnt < target && budget < 20000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (xfer_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL wait_xfer timeout: got %0d transfers expected %0d", xfer_cnt, target);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_xpos"},      64'(xpos), 64'd0);
        chk({tag, "_ypos"},      64'(ypos), 64'd0);
        chk({tag, "_monoc"},     64'(monoc), 64'd1);
        chk({tag, "_fall"},      64'(monoc_fall), 64'd0);
        chk({tag, "_color"},     64'(color_rgb), 64'hffff);
        chk({tag, "_flags"},     64'({sof, eol, eof}), 64'd0);
        chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
    endtask

    // Random 50% back-pressure.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: stall stability, scoreboard pop/compare and directed spot checks.
    logic [45:0] held;
    bit          stalled = 0;
    always @(negedge clk) begin
        logic [45:0] snap;
        pix_t        p;
        int          idx, f, x, y;
        snap = {out_valid, xpos, ypos, monoc, monoc_fall, color_rgb, sof, eol, eof, frame_cnt};
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (stalled) chk("stall_hold", 64'(snap), 64'(held));
            stalled = out_valid && !out_ready;
            held    = snap;
            if (out_valid && out_ready) begin
                idx = xfer_cnt;
                xfer_cnt++;
                x = int'(xpos);
                y = int'(ypos);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel: got (%0d,%0d) expected no transfer", x, y);
                end else begin
                    p = exp_q.pop_front();
                    if (x != p.x || y != p.y || monoc !== !p.ink || monoc_fall !== p.fall ||
                        color_rgb !== (p.ink ? 16'h0000 : 16'hffff) || sof !== p.sof ||
                        eol !== p.eol || eof !== p.eof || int'(frame_cnt) != p.fc) begin
                        errors++;
                        $display("FAIL pixel #%0d: got (%0d,%0d) m=%0b f=%0b c=%h s/l/e=%0b%0b%0b fc=%0d expected (%0d,%0d) m=%0b f=%0b s/l/e=%0b%0b%0b fc=%0d",
                                 idx, x, y, monoc, monoc_fall, color_rgb, sof, eol, eof, frame_cnt,
                                 p.x, p.y, !p.ink, p.fall, p.sof, p.eol, p.eof, p.fc);
                    end
                end
                if (idx < 3 * FP) begin
                    f = idx / FP;
                    if (f == 0 && x == XO && y == YO)         chk("digit0_seg_a", 64'(monoc), 64'd0);
                    if (f == 0 && x == XO + 4 && y == YO + 6) chk("digit0_center", 64'(monoc), 64'd1);
                    if (f == 0 && y == YO && x >= XO + PITCH && x < XO + PITCH + CWD - ST)
                        chk("digit1_top_row", 64'(monoc), 64'd1);
                    if (f == 1 && y == YO + 3 && x >= XO && (x - XO) % PITCH == 0)
                        chk("digit5_seg_f", 64'(monoc), 64'd0);
                    if (f == 1 && y == YO + 3 && x >= XO && (x - XO) % PITCH == CWD - 1)
                        chk("digit5_no_b", 64'(monoc), 64'd1);
                    if (f == 2 && y == YO + 1)
                        chk("digit8_fall_row", 64'(monoc_fall),
                            64'(x == 2 || x == 14 || x == 26 || x == 38));
                end
            end
        end
    end

    localparam int ABORT_IDX = 20 * H + 30;

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Frame 0: digits 0123 loaded while idle.
        @(posedge clk); #1 digit_in = 16'h0123; digit_load = 1'b1;
        @(posedge clk); #1 digit_load = 1'b0;
        chk("idle_no_valid", 64'(out_valid), 64'd0);
        push_frame(16'h0123, 0, FP);
        rand_ready = 1;
        en = 1'b1;

        // Mid-frame load of 5555 applies to frame 1 only.
        wait_xfer(500);
        @(posedge clk); #1 digit_in = 16'h5555; digit_load = 1'b1;
        push_frame(16'h5555, 1, FP);
        @(posedge clk); #1 digit_load = 1'b0;

        wait_xfer(FP + 500);
        @(posedge clk); #1 digit_in = 16'h8888; digit_load = 1'b1;
        push_frame(16'h8888, 2, FP);
        @(posedge clk); #1 digit_load = 1'b0;

        // Drop en around pixel (10,10) of frame 2: frame drains, then idle.
        wait_xfer(2 * FP + 10 * H + 10);
        @(posedge clk); #1 en = 1'b0;
        wait_xfer(3 * FP);
        repeat (5) @(posedge clk);
        #1;
        chk("drain_idle_valid", 64'(out_valid), 64'd0);
        chk("drain_frame_cnt", 64'(frame_cnt), 64'd3);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        // Frame 3 aborted by reset right after pixel (30,20) is accepted.
        push_frame(16'h8888, 3, ABORT_IDX + 1);
        en = 1'b1;
        wait_xfer(3 * FP + ABORT_IDX + 1);
        @(posedge clk); #1 rst_n = 1'b0; en = 1'b0;
        #1 chk_reset_vals("midframe_reset");
        chk("abort_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Restart with a load coincident with the (0,0) issue.
        @(posedge clk); #1 digit_in = 16'h4096; digit_load = 1'b1; en = 1'b1;
        push_frame(16'h4096, 0, FP);
        @(posedge clk); #1 digit_load = 1'b0;
        chk("restart_valid", 64'(out_valid), 64'd1);
        chk("restart_origin", 64'({xpos, ypos}), 64'd0);
        chk("restart_sof", 64'(sof), 64'd1);
        wait_xfer(3 * FP + ABORT_IDX + 1 + 5);
        @(posedge clk); #1 en = 1'b0;
        wait_xfer(4 * FP + ABORT_IDX + 1);
        repeat (5) @(posedge clk);
        #1;
        chk("final_valid", 64'(out_valid), 64'd0);
        chk("final_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
